// File: rtl/spi_rx.sv
// Mode-0 SPI peripheral receiver. SCK/CSN/SDI are oversampled in the clk_sys_i domain and
// deserialized MSB-first into a single-entry valid/ready holding register.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// WAIT_IDLE | after reset; ignore the bus until CSN is seen high
// IDLE      | CSN high, no frame in progress
// SHIFT     | CSN low, sampling SDI on each SCK rising edge
module spi_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_sys_i,
   input  logic       rst_i,
   input  logic       spi_sck_i,
   input  logic       spi_csn_i,
   input  logic       spi_sd_i,
   output logic [7:0] rx_data_o,
   output logic       rx_first_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       abort_o,
   output logic       overrun_o,
   input  logic       overrun_clr_i
);

   localparam int FW = $clog2(SYNC_STAGES + 2);
   localparam logic [FW-1:0] FLUSH_INIT = FW'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
   logic                   sck_s, csn_s, sdi_s;

   logic          sck_prev_q, sck_prev_d;
   logic          sample_q, sample_d;
   logic          sdi_smp_q, sdi_smp_d;
   logic          csn_p_q, csn_p_d;
   logic [FW-1:0] flush_q, flush_d;

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       first_q, first_d;

   logic [7:0] data_q, data_d;
   logic       rx_first_q, rx_first_d;
   logic       valid_q, valid_d;
   logic       abort_q, abort_d;
   logic       overrun_q, overrun_d;

   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign csn_s = csn_sync_q[SYNC_STAGES-1];
   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

   always_comb begin
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync_d = {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
      sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], spi_sd_i};

      // The sample strobe, its SDI bit and CSN are registered together so the
      // FSM always sees a consistent snapshot of the bus.
      sck_prev_d = sck_s;
      sample_d   = sck_s & ~sck_prev_q & ~csn_s;
      sdi_smp_d  = sdi_s;
      csn_p_d    = csn_s;
      flush_d    = (flush_q != '0) ? flush_q - 1'b1 : flush_q;

      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      data_d     = data_q;
      rx_first_d = rx_first_q;
      valid_d    = valid_q;
      abort_d    = 1'b0;
      overrun_d  = overrun_q;

      if (valid_q && rx_ready_i) begin
         valid_d = 1'b0;
      end
      if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         // The synchronizers reset to CSN high; wait until they hold real pin
         // samples so a frame already in progress is not mistaken for idle.
         WAIT_IDLE: begin
            if ((flush_q == '0) && csn_p_q) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            cnt_d = 3'd0;
            if (!csn_p_q) begin
               state_d = SHIFT;
               first_d = 1'b1;
            end
         end
         SHIFT: begin
            if (csn_p_q) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
               abort_d = (cnt_q != 3'd0);
            end else if (sample_q) begin
               shift_d = {shift_q[6:0], sdi_smp_q};
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  first_d = 1'b0;
                  if (!valid_q || rx_ready_i) begin
                     data_d     = {shift_q[6:0], sdi_smp_q};
                     rx_first_d = first_q;
                     valid_d    = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         sck_sync_q <= '0;
         csn_sync_q <= '1;
         sdi_sync_q <= '0;
         sck_prev_q <= 1'b0;
         sample_q   <= 1'b0;
         sdi_smp_q  <= 1'b0;
         csn_p_q    <= 1'b1;
         flush_q    <= FLUSH_INIT;
         state_q    <= WAIT_IDLE;
         shift_q    <= 8'h00;
         cnt_q      <= 3'd0;
         first_q    <= 1'b0;
         data_q     <= 8'h00;
         rx_first_q <= 1'b0;
         valid_q    <= 1'b0;
         abort_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         csn_sync_q <= csn_sync_d;
         sdi_sync_q <= sdi_sync_d;
         sck_prev_q <= sck_prev_d;
         sample_q   <= sample_d;
         sdi_smp_q  <= sdi_smp_d;
         csn_p_q    <= csn_p_d;
         flush_q    <= flush_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         data_q     <= data_d;
         rx_first_q <= rx_first_d;
         valid_q    <= valid_d;
         abort_q    <= abort_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_data_o  = data_q;
   assign rx_first_o = rx_first_q;
   assign rx_valid_o = valid_q;
   assign abort_o    = abort_q;
   assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed/randomized bench for spi_rx: accepted bytes are collected by a monitor and
// compared against the list of bytes the bench itself sent.
module tb_spi_rx;

   logic       clk_sys_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       spi_sck_i = 1'b0;
   logic       spi_csn_i = 1'b1;
   logic       spi_sd_i = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_first_o;
   logic       rx_valid_o;
   logic       rx_ready_i = 1'b0;
   logic       abort_o;
   logic       overrun_o;
   logic       overrun_clr_i = 1'b0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int sck_rise_cyc = 0;
   int abort_cycles = 0;
   int valid_rises = 0;
   int last_rise_cyc = 0;
   logic valid_prev = 1'b0;
   logic [8:0] acc_q[$];
   logic [8:0] exp_q[$];

   spi_rx #(.SYNC_STAGES(2)) dut (
      .clk_sys_i     (clk_sys_i),
      .rst_i         (rst_i),
      .spi_sck_i     (spi_sck_i),
      .spi_csn_i     (spi_csn_i),
      .spi_sd_i      (spi_sd_i),
      .rx_data_o     (rx_data_o),
      .rx_first_o    (rx_first_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .abort_o       (abort_o),
      .overrun_o     (overrun_o),
      .overrun_clr_i (overrun_clr_i)
   );

   always #5 clk_sys_i = ~clk_sys_i;
   always @(posedge clk_sys_i) cyc <= cyc + 1;

   always @(negedge clk_sys_i) begin
      if (rx_valid_o && rx_ready_i) acc_q.push_back({rx_first_o, rx_data_o});
      if (abort_o) abort_cycles++;
      if (rx_valid_o && !valid_prev) begin
         valid_rises++;
         last_rise_cyc = cyc;
      end
      valid_prev = rx_valid_o;
   end

   task automatic waitc(input int n);
      repeat (n) @(posedge clk_sys_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nbits, input int hp);
      for (int i = 0; i < nbits; i++) begin
         spi_sd_i = b[7 - (i % 8)];
         waitc(hp);
         spi_sck_i = 1'b1;
         sck_rise_cyc = cyc;
         waitc(hp);
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic check_acc(input string tag);
      chk({tag, "_count"}, acc_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), acc_q[i], exp_q[i]);
      acc_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int rise8;
      int rises0;
      int aborts0;
      int n;
      int hp;
      logic [7:0] r;

      waitc(3);
      chk("rst_data", rx_data_o, 8'h00);
      chk("rst_first", rx_first_o, 1'b0);
      chk("rst_valid", rx_valid_o, 1'b0);
      chk("rst_abort", abort_o, 1'b0);
      chk("rst_overrun", overrun_o, 1'b0);
      rst_i = 1'b0;
      waitc(6);

      // single byte, latency
      rises0 = valid_rises;
      rx_ready_i = 1'b1;
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'hA5, 8, 4);
      rise8 = sck_rise_cyc;
      waitc(10);
      spi_csn_i = 1'b1;
      waitc(8);
      exp_q.push_back({1'b1, 8'hA5});
      check_acc("t1");
      chk("t1_latency", last_rise_cyc - rise8, 4);
      chk("t1_pulses", valid_rises - rises0, 1);
      chk("t1_abort", abort_cycles, 0);
      chk("t1_overrun", overrun_o, 1'b0);

      // multi-byte frame, then a random frame
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'h01, 8, 4); exp_q.push_back({1'b1, 8'h01});
      send_bits(8'h80, 8, 4); exp_q.push_back({1'b0, 8'h80});
      send_bits(8'hFF, 8, 4); exp_q.push_back({1'b0, 8'hFF});
      spi_csn_i = 1'b1;
      waitc(8);
      check_acc("t2");
      for (int f = 0; f < 2; f++) begin
         n = 2 + $urandom_range(0, 2);
         spi_csn_i = 1'b0;
         waitc(2 + $urandom_range(0, 3));
         for (int k = 0; k < n; k++) begin
            r = 8'($urandom);
            hp = 2 + $urandom_range(0, 3);
            send_bits(r, 8, hp);
            exp_q.push_back({(k == 0), r});
         end
         waitc(4);
         spi_csn_i = 1'b1;
         waitc(8);
         check_acc($sformatf("t2r%0d", f));
      end

      // backpressure / overrun
      rx_ready_i = 1'b0;
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'h11, 8, 3);
      send_bits(8'h22, 8, 3);
      waitc(8);
      chk("t3_valid_held", rx_valid_o, 1'b1);
      chk("t3_data_held", rx_data_o, 8'h11);
      chk("t3_first_held", rx_first_o, 1'b1);
      chk("t3_overrun_set", overrun_o, 1'b1);
      rx_ready_i = 1'b1;
      waitc(1);
      rx_ready_i = 1'b0;
      waitc(2);
      chk("t3_valid_drop", rx_valid_o, 1'b0);
      exp_q.push_back({1'b1, 8'h11});
      check_acc("t3");
      spi_csn_i = 1'b1;
      waitc(6);
      chk("t3_overrun_sticky", overrun_o, 1'b1);
      overrun_clr_i = 1'b1;
      waitc(1);
      overrun_clr_i = 1'b0;
      chk("t3_overrun_clr", overrun_o, 1'b0);

      // accept in the exact cycle the next byte completes
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'h33, 8, 3);
      send_bits(8'h44, 7, 3);
      spi_sd_i = 1'b0;
      waitc(3);
      spi_sck_i = 1'b1;
      waitc(3);
      rx_ready_i = 1'b1;
      waitc(1);
      rx_ready_i = 1'b0;
      chk("t4_valid", rx_valid_o, 1'b1);
      chk("t4_data", rx_data_o, 8'h44);
      chk("t4_first", rx_first_o, 1'b0);
      chk("t4_overrun", overrun_o, 1'b0);
      spi_sck_i = 1'b0;
      waitc(3);
      exp_q.push_back({1'b1, 8'h33});
      check_acc("t4a");
      rx_ready_i = 1'b1;
      waitc(1);
      rx_ready_i = 1'b0;
      exp_q.push_back({1'b0, 8'h44});
      check_acc("t4b");
      spi_csn_i = 1'b1;
      waitc(6);

      // abort after a partial byte
      aborts0 = abort_cycles;
      rx_ready_i = 1'b1;
      spi_csn_i = 1'b0;
      waitc(3);
      r = 8'($urandom);
      send_bits(r, 5, 2 + $urandom_range(0, 2));
      waitc(4);
      spi_csn_i = 1'b1;
      waitc(8);
      chk("t5_abort_pulse", abort_cycles - aborts0, 1);
      check_acc("t5a");
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'h5A, 8, 3);
      waitc(4);
      spi_csn_i = 1'b1;
      waitc(8);
      exp_q.push_back({1'b1, 8'h5A});
      check_acc("t5b");
      chk("t5_no_extra_abort", abort_cycles - aborts0, 1);

      // reset in the middle of a frame
      aborts0 = abort_cycles;
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'($urandom), 3, 3);
      rst_i = 1'b1;
      waitc(2);
      rst_i = 1'b0;
      send_bits(8'($urandom), 8, 3);
      send_bits(8'($urandom), 5, 3);
      waitc(6);
      chk("t6_valid", rx_valid_o, 1'b0);
      check_acc("t6a");
      spi_csn_i = 1'b1;
      waitc(8);
      spi_csn_i = 1'b0;
      waitc(3);
      send_bits(8'hC3, 8, 3);
      waitc(4);
      spi_csn_i = 1'b1;
      waitc(8);
      exp_q.push_back({1'b1, 8'hC3});
      check_acc("t6b");
      chk("t6_abort", abort_cycles - aborts0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
SPI peripheral receiver, the receive-direction counterpart of the SPI peripheral transmitter. It oversamples the controller's SCK, CSN and SDI pins in the system clock domain, so no second clock domain and no CDC block are needed. It deserializes mode-0 (CPOL=0, CPHA=0), MSB-first bytes and presents them on a valid/ready byte interface to the Wishbone-side logic. It also reports frame-first-byte, aborted-partial-byte and overrun conditions.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers for SCK, CSN and SDI (minimum 2).

Ports:
clk_sys_i  input  1  system clock; all logic runs on its rising edge.
rst_i  input  1  synchronous, active-high reset.
spi_sck_i  input  1  SPI clock from the controller; asynchronous to clk_sys_i.
spi_csn_i  input  1  chip select, active low; asynchronous.
spi_sd_i  input  1  serial data from the controller (MOSI); asynchronous.
rx_data_o  output  8  received byte.
rx_first_o  output  1  qualifies rx_data_o: byte is the first of its CSN frame.
rx_valid_o  output  1  rx_data_o/rx_first_o hold an unconsumed byte.
rx_ready_i  input  1  consumer accepts the byte when rx_valid_o && rx_ready_i.
abort_o  output  1  one-cycle pulse: CSN deasserted with a partial byte pending.
overrun_o  output  1  sticky: a completed byte was dropped because the holding register was full.
overrun_clr_i  input  1  clears overrun_o.

Behaviour:
- Synchronizers: SCK, CSN and SDI each pass through SYNC_STAGES flops with identical depth, so the three stay mutually aligned. A further register on synced SCK gives the previous value for edge detection. CSN synchronizer flops reset to 1; SCK and SDI synchronizer flops reset to 0.
- Sample event: synced SCK = 1 and previous synced SCK = 0 while synced CSN = 0. SDI is taken from the synced SDI of the same cycle.
- Timing requirement on the controller: SCK high and low phases each last at least 2 clk_sys_i periods. SDI is stable for at least 1 clk_sys_i period on both sides of each SCK rising edge. Violating this is out of scope; no detection is required.
- State machine: WAIT_IDLE, IDLE, SHIFT.
  - Reset enters WAIT_IDLE. WAIT_IDLE ignores all SCK edges until synced CSN = 1 is seen, then moves to IDLE. This prevents joining a frame mid-byte after reset.
  - IDLE: synced CSN = 0 moves to SHIFT; the bit counter is 0 and the first flag is set to 1.
  - SHIFT, on each sample event: shift register <= {shift[6:0], sdi}; 3-bit counter increments and wraps 7 -> 0.
  - SHIFT, on the sample event where the counter is 7: a byte is complete.
    - Holding register empty, or rx_ready_i = 1 this cycle: on the next clock rx_data_o = {shift[6:0], sdi}, rx_first_o = first flag, rx_valid_o = 1, and the first flag clears.
    - Otherwise: the byte is dropped, the existing holding contents are unchanged, overrun_o <= 1, and the first flag still clears.
  - SHIFT, synced CSN returns to 1: go to IDLE and reset the counter to 0.
    - If the counter was nonzero, abort_o pulses for exactly 1 cycle and the partial bits are discarded.
    - If the counter was 0, no pulse.
    - A byte already in the holding register is kept.
- Latency: rx_valid_o rises SYNC_STAGES + 2 clk_sys_i cycles after the 8th SCK rising edge reaches spi_sck_i, with SYNC_STAGES = 2 giving 4.
- Handshake: rx_valid_o, rx_data_o and rx_first_o hold until the cycle with rx_valid_o && rx_ready_i.
  - rx_valid_o drops on the next clock unless a new byte completes in that same accept cycle, in which case the new byte loads and rx_valid_o stays 1.
  - rx_ready_i while rx_valid_o = 0 has no effect.
- Overrun: overrun_o is cleared by overrun_clr_i on the next clock. A simultaneous set and clear leaves overrun_o = 1 (set wins).
- Reset values: rx_data_o = 0x00, rx_first_o = 0, rx_valid_o = 0, abort_o = 0, overrun_o = 0; shift register = 0, counter = 0, state = WAIT_IDLE.
- Reset mid-frame: all state clears. Bits and bytes still arriving in that frame are ignored until CSN goes high and a new frame starts.

Test Plan:
1. Single byte: CSN low, send 0xA5 MSB-first with SCK high/low 4 cycles each, rx_ready_i = 1 → exactly one rx_valid_o pulse with rx_data_o = 0xA5, rx_first_o = 1, 4 cycles after the 8th SCK rise; abort_o and overrun_o stay 0.
2. Multi-byte frame: bytes 0x01, 0x80, 0xFF in one CSN frame, ready held 1 → three bytes in order; rx_first_o = 1 only on 0x01.
3. Backpressure/overrun: rx_ready_i = 0, send 0x11 then 0x22 → rx_data_o stays 0x11 and overrun_o = 1. Then raise ready → 0x11 consumed, rx_valid_o = 0. Pulse overrun_clr_i → overrun_o = 0.
4. Accept-and-complete collision: hold 0x33, assert rx_ready_i in the exact cycle 0x44 completes → rx_valid_o stays 1, rx_data_o = 0x44, overrun_o = 0.
5. Abort: CSN low, 5 SCK edges, CSN high → one abort_o pulse and no rx_valid_o. Next frame sends 0x5A → received correctly with rx_first_o = 1.
6. Reset mid-frame: assert rst_i after 3 bits of a byte while CSN stays low, continue 13 more SCK edges → no rx_valid_o. CSN high then a new frame sending 0xC3 → 0xC3 received.
